// File: rtl/mram_link_pkg.sv
// Shared definitions for the MRAM serial link: word-select encodings
// used by both the serialiser and the receiver, and the receiver FSM states.
package mram_link_pkg;

  localparam logic [1:0] WORD_SEL_NONE  = 2'b00;
  localparam logic [1:0] WORD_SEL_LOWER = 2'b01;
  localparam logic [1:0] WORD_SEL_UPPER = 2'b10;
  localparam logic [1:0] WORD_SEL_FULL  = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// Receive side of the MRAM serial link. Shifts in an LSB-first bit stream
// and presents it as a full word or a half word with matching byte enables,
// flagged by a single-cycle data_valid.
module serial_to_parallel
  import mram_link_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           word_sel,
  input  logic                 data_in,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic [1:0]           byte_en,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int HALF = BUS_WIDTH / 2;
  localparam int CW   = $clog2(BUS_WIDTH) + 1;

  rx_state_t            state;
  logic [BUS_WIDTH-1:0] shreg;
  logic [BUS_WIDTH-1:0] shreg_next;
  logic [BUS_WIDTH-1:0] word_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        last_cnt;
  logic [1:0]           sel_q;

  // New bits enter at the MSB so the first (LSB) bit ends up at the bottom
  // after a full frame, or at the bottom of the upper half after a half frame.
  assign shreg_next = {data_in, shreg[BUS_WIDTH-1:1]};

  // Index of the final bit of the current frame.
  assign last_cnt = (sel_q == WORD_SEL_FULL) ? CW'(BUS_WIDTH - 1) : CW'(HALF - 1);

  // Place the received bits into the correct half of the output word.
  always_comb begin
    word_next = '0;
    case (sel_q)
      WORD_SEL_FULL:  word_next = shreg_next;
      WORD_SEL_LOWER: word_next[HALF-1:0] = shreg_next[BUS_WIDTH-1:HALF];
      WORD_SEL_UPPER: word_next[BUS_WIDTH-1:HALF] = shreg_next[BUS_WIDTH-1:HALF];
      default:        word_next = '0;
    endcase
  end

  assign busy = (state != RX_IDLE);

  // Receiver FSM, shift register, bit counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sel_q      <= WORD_SEL_NONE;
      data_out   <= '0;
      byte_en    <= 2'b00;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Pulses last one cycle; they are never stretched by a stall.
      data_valid <= 1'b0;
      err        <= 1'b0;
      if (en) begin
        case (state)
          RX_IDLE: begin
            if (start) begin
              if (word_sel == WORD_SEL_NONE) begin
                err <= 1'b1;
              end else begin
                sel_q <= word_sel;
                shreg <= '0;
                cnt   <= '0;
                state <= RX_RECV;
              end
            end
          end
          RX_RECV: begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (cnt == last_cnt) begin
              data_out   <= word_next;
              byte_en    <= sel_q;
              data_valid <= 1'b1;
              state      <= RX_DONE;
            end
          end
          RX_DONE: begin
            state <= RX_IDLE;
          end
          default: begin
            state <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: expected words are queued when a
// frame is started and compared when data_valid appears.
module tb_serial_to_parallel;

  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    word_sel = 2'b00;
  logic          data_in = 1'b0;
  logic [BW-1:0] data_out;
  logic [1:0]    byte_en;
  logic          data_valid;
  logic          busy;
  logic          err;

  serial_to_parallel #(.BUS_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .word_sel   (word_sel),
    .data_in    (data_in),
    .data_out   (data_out),
    .byte_en    (byte_en),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [BW-1:0] exp_data_q[$];
  logic [1:0]    exp_be_q[$];
  logic [BW-1:0] last_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and score any output word that appeared.
  task automatic tick();
    @(posedge clk);
    #1;
    if (data_valid) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_valid", 32'(data_valid), 32'd0);
      end else begin
        logic [BW-1:0] ed;
        logic [1:0]    eb;
        ed = exp_data_q.pop_front();
        eb = exp_be_q.pop_front();
        check("data_out", 32'(data_out), 32'(ed));
        check("byte_en", 32'(byte_en), 32'(eb));
        $display("frame out data=%04h be=%b", data_out, byte_en);
      end
    end
  endtask

  // Send one frame: stall_at >= 0 inserts stall_len en-low cycles after that
  // bit; noise re-asserts start and scrambles word_sel while receiving.
  task automatic send_frame(input logic [BW-1:0] word, input logic [1:0] sel,
                            input int stall_at, input int stall_len, input bit noise);
    int n;
    logic [BW-1:0] exp_word;
    logic [BW-1:0] bits;
    n = (sel == 2'b11) ? BW : BW / 2;
    case (sel)
      2'b11:   begin exp_word = word; bits = word; end
      2'b01:   begin exp_word = {8'h00, word[7:0]}; bits = {8'h00, word[7:0]}; end
      default: begin exp_word = {word[15:8], 8'h00}; bits = {8'h00, word[15:8]}; end
    endcase
    exp_data_q.push_back(exp_word);
    exp_be_q.push_back(sel);
    en = 1'b1;
    start = 1'b1;
    word_sel = sel;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("data_out_held", 32'(data_out), 32'(last_word));
    for (int i = 0; i < n; i++) begin
      data_in = bits[i];
      if (noise) begin
        start = 1'b1;
        word_sel = 2'($urandom_range(0, 3));
      end
      tick();
      check("dv_timing", 32'(data_valid), (i == n - 1) ? 32'd1 : 32'd0);
      if (i == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_no_dv", 32'(data_valid), 32'd0);
          check("stall_busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
      end
    end
    start = 1'b0;
    tick();
    check("dv_width", 32'(data_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    last_word = exp_word;
  endtask

  initial begin
    logic [BW-1:0] rw;
    logic [1:0]    rs;
    #2;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_byte_en", 32'(byte_en), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #20;
    rst = 1'b0;
    tick();

    send_frame(16'hA5C3, 2'b11, -1, 0, 1'b0);
    send_frame(16'h003C, 2'b01, -1, 0, 1'b0);
    send_frame(16'h9600, 2'b10, -1, 0, 1'b0);
    send_frame(16'h1234, 2'b11, 5, 3, 1'b0);

    // Illegal word_sel on start.
    en = 1'b1;
    start = 1'b1;
    word_sel = 2'b00;
    tick();
    start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    tick();
    check("err_width", 32'(err), 32'd0);
    $display("illegal start err handled");

    // Extra starts and word_sel changes mid-frame are ignored.
    send_frame(16'h5A0F, 2'b11, -1, 0, 1'b1);
    send_frame(16'h00C7, 2'b01, -1, 0, 1'b1);

    // Reset in the middle of a frame.
    start = 1'b1;
    word_sel = 2'b11;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_byte_en", 32'(byte_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_word = '0;
    $display("mid-frame reset applied");
    tick();
    check("after_rst_valid", 32'(data_valid), 32'd0);
    send_frame(16'hFFFF, 2'b11, -1, 0, 1'b0);

    // Loopback of random words through a behavioural serialiser.
    for (int k = 0; k < 9; k++) begin
      rw = 16'($urandom);
      rs = 2'((k % 3) + 1);
      send_frame(rw, rs, -1, 0, 1'b0);
    end

    check("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
